// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues in-order fetches to instruction
// memory, buffers returned words with their fall-through PC, and handles
// branch redirects by flushing the queue and discarding in-flight responses.
module if_prefetch_stage #(
  parameter int unsigned   N           = 32,
  parameter int unsigned   DEPTH       = 4,
  parameter int unsigned   INSTR_BYTES = 4,
  parameter logic [N-1:0]  RESET_PC    = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branchTakenIn,
  input  logic [N-1:0] branchAddressIn,
  output logic         imemReq,
  output logic [N-1:0] imemAddr,
  input  logic         imemGnt,
  input  logic         imemRspValid,
  input  logic [N-1:0] imemRspData,
  output logic         instValidOut,
  output logic [N-1:0] PCOut,
  output logic [N-1:0] instructionOut
);

  localparam int unsigned   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CNT_W   = $clog2(DEPTH + 1);
  localparam logic [N-1:0]  STEP    = N'(INSTR_BYTES);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [N-1:0]     fetch_pc_q, fetch_pc_d;
  logic [N-1:0]     rsp_pc_q,   rsp_pc_d;
  logic [CNT_W-1:0] occ_q,      occ_d;
  logic [CNT_W-1:0] pend_q,     pend_d;
  logic [CNT_W-1:0] drop_q,     drop_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;

  logic [N-1:0]     mem_pc_q  [DEPTH];
  logic [N-1:0]     mem_ins_q [DEPTH];

  logic             req_c;
  logic             fire_c;
  logic             rsp_acc_c;
  logic             push_c;
  logic             pop_c;
  logic             occ_nz_c;

  // Handshake qualifiers; a redirect suppresses new requests, pushes and pops.
  always_comb begin
    occ_nz_c  = (occ_q != '0);
    req_c     = rst && (({1'b0, occ_q} + {1'b0, pend_q}) < DEPTH_C) && !branchTakenIn;
    fire_c    = req_c && imemGnt;
    rsp_acc_c = imemRspValid && (pend_q != '0);
    push_c    = rsp_acc_c && !branchTakenIn && (drop_q == '0);
    pop_c     = occ_nz_c && !freeze && !branchTakenIn;
  end

  // Next-state: redirect flushes the queue and marks in-flight fetches as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (branchTakenIn) begin
      fetch_pc_d = branchAddressIn;
      rsp_pc_d   = branchAddressIn;
      occ_d      = '0;
      rd_ptr_d   = wr_ptr_q;
      pend_d     = pend_q - CNT_W'(rsp_acc_c);
      drop_d     = pend_q - CNT_W'(rsp_acc_c);
    end else begin
      if (fire_c) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      pend_d = pend_q + CNT_W'(fire_c) - CNT_W'(rsp_acc_c);
      if (rsp_acc_c && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push_c) begin
        rsp_pc_d = rsp_pc_q + STEP;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage; contents are only observed through occ, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_pc_q[wr_ptr_q]  <= rsp_pc_q + STEP;
      mem_ins_q[wr_ptr_q] <= imemRspData;
    end
  end

  // Output drive; head fields read as zero while the queue is empty.
  always_comb begin
    imemReq        = req_c;
    imemAddr       = fetch_pc_q;
    instValidOut   = occ_nz_c && !branchTakenIn;
    PCOut          = occ_nz_c ? mem_pc_q[rd_ptr_q]  : '0;
    instructionOut = occ_nz_c ? mem_ins_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage: an in-order memory responder and a
// queue-based reference model of requests in flight and buffered instructions.
module tb_if_prefetch_stage;

  localparam int          DEPTH_I = 4;
  localparam logic [31:0] IB      = 32'd4;
  localparam logic [31:0] RPC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branchTakenIn = 1'b0;
  logic [31:0] branchAddressIn = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRspValid = 1'b0;
  logic [31:0] imemRspData = '0;
  logic        instValidOut;
  logic [31:0] PCOut;
  logic [31:0] instructionOut;

  if_prefetch_stage #(
    .N(32), .DEPTH(4), .INSTR_BYTES(4), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .branchTakenIn(branchTakenIn), .branchAddressIn(branchAddressIn),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .instValidOut(instValidOut), .PCOut(PCOut), .instructionOut(instructionOut)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        outq[$];
  ent_t        fifo[$];
  logic [31:0] m_fetch = RPC;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic cycle(input int p_gnt, input int p_rsp, input int p_frz, input int p_br,
                       input logic [31:0] tgt, input bit fix_tgt);
    bit          e_req, e_val, fire, acc;
    logic [31:0] e_pc, e_ins;
    req_t        r;
    ent_t        e;
    @(negedge clk);
    imemGnt       = ($urandom_range(99) < p_gnt);
    freeze        = ($urandom_range(99) < p_frz);
    branchTakenIn = ($urandom_range(99) < p_br);
    if (fix_tgt)                     branchAddressIn = tgt;
    else if ($urandom_range(3) == 0) branchAddressIn = 32'hFFFF_FFF8;
    else                             branchAddressIn = $urandom & 32'h0000_FFFC;
    if (outq.size() > 0) begin
      imemRspValid = ($urandom_range(99) < p_rsp);
      imemRspData  = word_of(outq[0].addr);
    end else begin
      imemRspValid = ($urandom_range(9) == 0);
      imemRspData  = $urandom;
    end
    #1;
    e_req = ((fifo.size() + outq.size()) < DEPTH_I) && !branchTakenIn;
    e_val = (fifo.size() > 0) && !branchTakenIn;
    e_pc  = (fifo.size() > 0) ? fifo[0].pc  : 32'h0;
    e_ins = (fifo.size() > 0) ? fifo[0].ins : 32'h0;
    chk("imemReq",        32'(imemReq),      32'(e_req));
    chk("imemAddr",       imemAddr,          m_fetch);
    chk("instValidOut",   32'(instValidOut), 32'(e_val));
    chk("PCOut",          PCOut,             e_pc);
    chk("instructionOut", instructionOut,    e_ins);

    fire = e_req && imemGnt;
    acc  = imemRspValid && (outq.size() > 0);
    if (branchTakenIn) begin
      if (acc) void'(outq.pop_front());
      foreach (outq[i]) outq[i].stale = 1'b1;
      fifo.delete();
      m_fetch = branchAddressIn;
    end else begin
      if ((fifo.size() > 0) && !freeze) void'(fifo.pop_front());
      if (acc) begin
        r = outq.pop_front();
        if (!r.stale) begin
          e.pc  = r.addr + IB;
          e.ins = imemRspData;
          fifo.push_back(e);
        end
      end
      if (fire) begin
        r.addr  = m_fetch;
        r.stale = 1'b0;
        outq.push_back(r);
        m_fetch = m_fetch + IB;
      end
    end
  endtask

  // Assert reset (possibly mid-stream), check outputs clear at once, release quietly.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_imemReq",  32'(imemReq),      32'h0);
    chk("rst_valid",    32'(instValidOut), 32'h0);
    chk("rst_PCOut",    PCOut,             32'h0);
    chk("rst_instr",    instructionOut,    32'h0);
    chk("rst_imemAddr", imemAddr,          RPC);
    imemGnt       = 1'b0;
    imemRspValid  = 1'b0;
    branchTakenIn = 1'b0;
    freeze        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    outq.delete();
    fifo.delete();
    m_fetch = RPC;
  endtask

  initial begin
    do_reset();
    // Streaming with immediate grant and single-cycle response.
    repeat (20) cycle(100, 100, 0, 0, 32'h0, 1'b0);
    // Long freeze fills the queue; then drain.
    repeat (10) cycle(100, 100, 100, 0, 32'h0, 1'b0);
    chk("freeze_full_req", 32'(imemReq), 32'h0);
    repeat (10) cycle(100, 100, 0, 0, 32'h0, 1'b0);
    // Grant withheld: address must hold.
    repeat (3) cycle(0, 100, 0, 0, 32'h0, 1'b0);
    // Two fetches in flight, then redirect to 0x100.
    do_reset();
    repeat (2) cycle(100, 0, 0, 0, 32'h0, 1'b0);
    cycle(0, 0, 0, 100, 32'h0000_0100, 1'b1);
    repeat (8) cycle(100, 100, 0, 0, 32'h0, 1'b0);
    // Redirect while frozen with a partly full queue.
    repeat (6) cycle(100, 100, 100, 0, 32'h0, 1'b0);
    cycle(100, 100, 100, 100, 32'h0000_0100, 1'b1);
    repeat (4) cycle(100, 100, 0, 0, 32'h0, 1'b0);
    // Random mixes, including back-to-back branches and address wrap.
    repeat (1500) cycle(70, 60, 30, 8, 32'h0, 1'b0);
    repeat (300)  cycle(90, 90, 10, 40, 32'h0, 1'b0);
    do_reset();
    repeat (1500) cycle(50, 40, 50, 5, 32'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
